// File: rtl/ballot_pkg.sv
// rtl/ballot_pkg.sv - shared constants and state type for the ballot collector
package ballot_pkg;

  localparam int NUM_VOTERS          = 5;
  localparam int NUM_CAND            = 3;
  localparam int VOTER_W             = 3;
  localparam int DEFAULT_TIMEOUT_CYC = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/ballot_collector_if.sv
// rtl/ballot_collector_if.sv - ballot offer port (valid/ready handshake plus payload)
interface ballot_collector_if;
  import ballot_pkg::*;

  logic                ballot_valid;
  logic                ballot_ready;
  logic [VOTER_W-1:0]  ballot_voter;
  logic [NUM_CAND-1:0] ballot_choice;

  modport master (
    output ballot_valid,
    output ballot_voter,
    output ballot_choice,
    input  ballot_ready
  );

  modport slave (
    input  ballot_valid,
    input  ballot_voter,
    input  ballot_choice,
    output ballot_ready
  );

endinterface

// File: rtl/ballot_checker.sv
// rtl/ballot_checker.sv - combinational ballot legality check, shareable by other front-ends
module ballot_checker
  import ballot_pkg::*;
(
  input  logic [VOTER_W-1:0]    voter,
  input  logic [NUM_CAND-1:0]   choice,
  input  logic [NUM_VOTERS-1:0] voted_mask,
  output logic                  is_valid,
  output logic                  is_repeat
);

  logic in_range;
  logic one_hot;

  always_comb begin
    in_range  = (voter < VOTER_W'(NUM_VOTERS));
    one_hot   = $onehot(choice);
    is_valid  = in_range && one_hot;
    // Loop instead of voted_mask[voter]: ids 5..7 must not index past the mask.
    is_repeat = 1'b0;
    for (int i = 0; i < NUM_VOTERS; i++) begin
      if ((voter == VOTER_W'(i)) && voted_mask[i]) begin
        is_repeat = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ballot_collector.sv
// rtl/ballot_collector.sv - voting round FSM, timeout timer and per-voter ballot storage
// Optional BALLOT_REVOTE_EN: a repeat legal ballot overwrites the stored one instead of being rejected.
module ballot_collector
  import ballot_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  ballot_collector_if.slave     bal,
  output logic [NUM_CAND-1:0]   A,
  output logic [NUM_CAND-1:0]   B,
  output logic [NUM_CAND-1:0]   C,
  output logic [NUM_CAND-1:0]   D,
  output logic [NUM_CAND-1:0]   E,
  output logic [NUM_VOTERS-1:0] voted_mask,
  output logic                  ballots_done,
  input  logic                  ack,
  output logic                  reject
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t              state_q;
  state_t              state_d;
  logic [TW-1:0]       timer_q;
  logic [NUM_CAND-1:0] ballot_q [NUM_VOTERS];

  logic                  is_valid;
  logic                  is_repeat;
  logic                  handshake;
  logic                  accept;
  logic                  timeout_hit;
  logic [NUM_VOTERS-1:0] voter_onehot;
  logic [NUM_VOTERS-1:0] mask_next;

  ballot_checker u_checker (
    .voter      (bal.ballot_voter),
    .choice     (bal.ballot_choice),
    .voted_mask (voted_mask),
    .is_valid   (is_valid),
    .is_repeat  (is_repeat)
  );

  assign bal.ballot_ready = (state_q == COLLECT);
  assign handshake        = bal.ballot_valid && bal.ballot_ready;
  assign timeout_hit      = (timer_q == TW'(TIMEOUT_CYC - 1));

`ifdef BALLOT_REVOTE_EN
  assign accept = handshake && is_valid;
`else
  assign accept = handshake && is_valid && !is_repeat;
`endif

  always_comb begin
    voter_onehot = '0;
    for (int i = 0; i < NUM_VOTERS; i++) begin
      voter_onehot[i] = (bal.ballot_voter == VOTER_W'(i));
    end
    // A revote leaves the mask untouched; a first vote sets its bit.
    mask_next = voted_mask;
    if (accept && !is_repeat) begin
      mask_next = voted_mask | voter_onehot;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = COLLECT;
      end
      COLLECT: begin
        if ((&mask_next) || timeout_hit) state_d = DONE;
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q      <= '0;
      voted_mask   <= '0;
      ballots_done <= 1'b0;
      reject       <= 1'b0;
      for (int i = 0; i < NUM_VOTERS; i++) ballot_q[i] <= '0;
    end else begin
      reject       <= handshake && !accept;
      ballots_done <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            timer_q    <= '0;
            voted_mask <= '0;
            for (int i = 0; i < NUM_VOTERS; i++) ballot_q[i] <= '0;
          end
        end
        COLLECT: begin
          timer_q    <= timer_q + TW'(1);
          voted_mask <= mask_next;
          for (int i = 0; i < NUM_VOTERS; i++) begin
            if (accept && voter_onehot[i]) ballot_q[i] <= bal.ballot_choice;
          end
        end
        default: ;
      endcase
    end
  end

  assign A = ballot_q[0];
  assign B = ballot_q[1];
  assign C = ballot_q[2];
  assign D = ballot_q[3];
  assign E = ballot_q[4];

endmodule

// File: tb/tb_ballot_collector.sv
// tb/tb_ballot_collector.sv - vector table, directed corner cases and randomized model check
module tb_ballot_collector;
  import ballot_pkg::*;

  localparam int TB_TIMEOUT = 8;
`ifdef BALLOT_REVOTE_EN
  localparam bit REVOTE = 1'b1;
`else
  localparam bit REVOTE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ack = 1'b0;
  logic [2:0] A, B, C, D, E;
  logic [4:0] voted_mask;
  logic ballots_done, reject;

  ballot_collector_if bif ();

  ballot_collector #(.TIMEOUT_CYC(TB_TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bal          (bif),
    .A            (A),
    .B            (B),
    .C            (C),
    .D            (D),
    .E            (E),
    .voted_mask   (voted_mask),
    .ballots_done (ballots_done),
    .ack          (ack),
    .reject       (reject)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic v, input logic [2:0] vo,
                       input logic [2:0] ch, input logic a);
    start              = s;
    bif.ballot_valid   = v;
    bif.ballot_voter   = vo;
    bif.ballot_choice  = ch;
    ack                = a;
  endtask

  function automatic logic [14:0] bus();
    return {A, B, C, D, E};
  endfunction

  typedef struct {
    logic        s, v;
    logic [2:0]  vo, ch;
    logic        a;
    logic        rej;
    logic [4:0]  mask;
    logic        done, rdy;
    logic [14:0] bus;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic s, input logic v, input logic [2:0] vo, input logic [2:0] ch,
                     input logic a, input logic rej, input logic [4:0] mask, input logic done,
                     input logic rdy, input logic [14:0] b);
    vec_t r;
    r.s = s; r.v = v; r.vo = vo; r.ch = ch; r.a = a;
    r.rej = rej; r.mask = mask; r.done = done; r.rdy = rdy; r.bus = b;
    vq.push_back(r);
  endtask

  // Behavioural reference: rules of a round in terms of elapsed COLLECT cycles.
  int         m_state;
  logic [2:0] m_bal [5];
  logic [4:0] m_mask;
  int         m_cycles;
  logic       m_done, m_rej;

  task automatic model_reset();
    m_state = 0; m_mask = '0; m_cycles = 0; m_done = 0; m_rej = 0;
    for (int i = 0; i < 5; i++) m_bal[i] = '0;
  endtask

  task automatic model_edge(input logic s, input logic v, input logic [2:0] vo,
                            input logic [2:0] ch, input logic a);
    bit ok, rep;
    m_rej = 0;
    if (m_state == 0) begin
      if (s) begin
        for (int i = 0; i < 5; i++) m_bal[i] = '0;
        m_mask = '0; m_cycles = 0; m_state = 1;
      end
    end else if (m_state == 1) begin
      if (v) begin
        ok  = (vo < 5) && ($countones(ch) == 1);
        rep = ok && m_mask[vo];
        if (ok && (!rep || REVOTE)) begin
          m_bal[vo] = ch;
          m_mask[vo] = 1'b1;
        end else begin
          m_rej = 1;
        end
      end
      m_cycles++;
      if (m_mask == 5'b11111 || m_cycles == TB_TIMEOUT) m_state = 2;
    end else begin
      if (a) m_state = 0;
    end
    m_done = (m_state == 2);
  endtask

  initial begin
    logic [2:0] rep_c;
    int cyc;

    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_bus", 32'(bus()), 32'h0);
    chk("reset_mask", 32'(voted_mask), 32'h0);
    chk("reset_done", 32'(ballots_done), 32'h0);
    chk("reset_reject", 32'(reject), 32'h0);
    chk("reset_ready", 32'(bif.ballot_ready), 32'h0);

    rep_c = REVOTE ? 3'b100 : 3'b010;
    //  s  v  vo  ch     a  rej  mask      done rdy bus {A,B,C,D,E}
    add(1, 0, 0, 3'b000, 0, 0, 5'b00000, 0, 1, 15'b000_000_000_000_000);
    add(0, 1, 0, 3'b001, 0, 0, 5'b00001, 0, 1, 15'b001_000_000_000_000);
    add(0, 1, 1, 3'b001, 0, 0, 5'b00011, 0, 1, 15'b001_001_000_000_000);
    add(0, 1, 2, 3'b010, 0, 0, 5'b00111, 0, 1, 15'b001_001_010_000_000);
    add(0, 1, 3, 3'b100, 0, 0, 5'b01111, 0, 1, 15'b001_001_010_100_000);
    add(0, 1, 4, 3'b001, 0, 0, 5'b11111, 1, 0, 15'b001_001_010_100_001);
    add(0, 1, 0, 3'b010, 0, 0, 5'b11111, 1, 0, 15'b001_001_010_100_001);
    add(1, 0, 0, 3'b000, 1, 0, 5'b11111, 0, 0, 15'b001_001_010_100_001);
    add(1, 0, 0, 3'b000, 0, 0, 5'b00000, 0, 1, 15'b000_000_000_000_000);
    add(0, 1, 5, 3'b001, 0, 1, 5'b00000, 0, 1, 15'b000_000_000_000_000);
    add(0, 1, 0, 3'b000, 0, 1, 5'b00000, 0, 1, 15'b000_000_000_000_000);
    add(0, 1, 0, 3'b011, 0, 1, 5'b00000, 0, 1, 15'b000_000_000_000_000);
    add(0, 1, 2, 3'b010, 0, 0, 5'b00100, 0, 1, 15'b000_000_010_000_000);
    add(0, 1, 2, 3'b100, 0, !REVOTE, 5'b00100, 0, 1, {6'b0, rep_c, 6'b0});
    add(0, 0, 0, 3'b000, 0, 0, 5'b00100, 0, 1, {6'b0, rep_c, 6'b0});
    add(0, 1, 0, 3'b001, 0, 0, 5'b00101, 0, 1, {3'b001, 3'b0, rep_c, 6'b0});
    add(0, 0, 0, 3'b000, 0, 0, 5'b00101, 1, 0, {3'b001, 3'b0, rep_c, 6'b0});
    add(0, 0, 0, 3'b000, 1, 0, 5'b00101, 0, 0, {3'b001, 3'b0, rep_c, 6'b0});

    foreach (vq[i]) begin
      drive(vq[i].s, vq[i].v, vq[i].vo, vq[i].ch, vq[i].a);
      tick();
      chk($sformatf("vec%0d_reject", i), 32'(reject), 32'(vq[i].rej));
      chk($sformatf("vec%0d_mask", i), 32'(voted_mask), 32'(vq[i].mask));
      chk($sformatf("vec%0d_done", i), 32'(ballots_done), 32'(vq[i].done));
      chk($sformatf("vec%0d_ready", i), 32'(bif.ballot_ready), 32'(vq[i].rdy));
      chk($sformatf("vec%0d_bus", i), 32'(bus()), 32'(vq[i].bus));
    end

    // Timeout round: only voters 0 and 3 vote.
    drive(1, 0, 0, 0, 0);
    tick();
    cyc = 0;
    while (bif.ballot_ready && cyc < 20) begin
      if (cyc == 1)      drive(0, 1, 0, 3'b010, 0);
      else if (cyc == 4) drive(0, 1, 3, 3'b001, 0);
      else               drive(0, 0, 0, 3'b000, 0);
      tick();
      cyc++;
    end
    drive(0, 0, 0, 0, 0);
    chk("timeout_cycles", 32'(cyc), 32'(TB_TIMEOUT));
    chk("timeout_done", 32'(ballots_done), 32'h1);
    chk("timeout_mask", 32'(voted_mask), 32'b01001);
    chk("timeout_bus", 32'(bus()), 32'(15'b010_000_000_001_000));
    drive(0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("timeout_ack_done", 32'(ballots_done), 32'h0);

    // Asynchronous reset in the middle of a round.
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 3'b001, 0); tick();
    drive(0, 1, 1, 3'b010, 0); tick();
    drive(0, 1, 2, 3'b100, 0); tick();
    drive(0, 1, 6, 3'b001, 0); tick();
    drive(0, 0, 0, 0, 0);
    chk("pre_rst_mask", 32'(voted_mask), 32'b00111);
    chk("pre_rst_reject", 32'(reject), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_bus", 32'(bus()), 32'h0);
    chk("async_rst_mask", 32'(voted_mask), 32'h0);
    chk("async_rst_done", 32'(ballots_done), 32'h0);
    chk("async_rst_reject", 32'(reject), 32'h0);
    chk("async_rst_ready", 32'(bif.ballot_ready), 32'h0);
    tick();
    rst = 1'b0;
    drive(0, 1, 0, 3'b001, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("post_rst_ready", 32'(bif.ballot_ready), 32'h0);
    chk("post_rst_idle_reject", 32'(reject), 32'h0);
    chk("post_rst_idle_mask", 32'(voted_mask), 32'h0);

    // Randomized traffic against the reference model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic s, v, a;
      logic [2:0] vo, ch;
      s  = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 3) == 0);
      v  = ($urandom_range(0, 3) != 0);
      vo = 3'($urandom_range(0, 6));
      ch = ($urandom_range(0, 9) < 7) ? 3'(1 << $urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      drive(s, v, vo, ch, a);
      model_edge(s, v, vo, ch, a);
      tick();
      chk($sformatf("rnd%0d_bus", n), 32'(bus()),
          32'({m_bal[0], m_bal[1], m_bal[2], m_bal[3], m_bal[4]}));
      chk($sformatf("rnd%0d_mask", n), 32'(voted_mask), 32'(m_mask));
      chk($sformatf("rnd%0d_done", n), 32'(ballots_done), 32'(m_done));
      chk($sformatf("rnd%0d_reject", n), 32'(reject), 32'(m_rej));
      chk($sformatf("rnd%0d_ready", n), 32'(bif.ballot_ready), 32'(m_state == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
